// File: rtl/vram_scheduler_if.sv
// rtl/vram_scheduler_if.sv - VRAM scheduler bus bundle: sync position, CPU port, VRAM port, tile outputs
interface vram_scheduler_if #(
  parameter int ADDR_W = 14
);
  logic [8:0]        xPos;
  logic [8:0]        yPos;
  logic              vSync;
  logic              cpuReq;
  logic              cpuWe;
  logic [ADDR_W-1:0] cpuAddr;
  logic [7:0]        cpuWData;
  logic              cpuAck;
  logic [7:0]        cpuRData;
  logic [ADDR_W-1:0] ramAddr;
  logic              ramWe;
  logic [7:0]        ramWData;
  logic [7:0]        ramRData;
  logic [7:0]        tileName;
  logic [7:0]        tilePattern;
  logic              patValid;
  logic [15:0]       stallCount;

  modport master (
    output xPos, yPos, vSync, cpuReq, cpuWe, cpuAddr, cpuWData, ramRData,
    input  cpuAck, cpuRData, ramAddr, ramWe, ramWData, tileName, tilePattern,
           patValid, stallCount
  );

  modport slave (
    input  xPos, yPos, vSync, cpuReq, cpuWe, cpuAddr, cpuWData, ramRData,
    output cpuAck, cpuRData, ramAddr, ramWe, ramWData, tileName, tilePattern,
           patValid, stallCount
  );
endinterface

// File: rtl/vram_scheduler.sv
// rtl/vram_scheduler.sv - time-slot VRAM arbiter between video tile fetch and CPU
// Optional stall counter built only when VRAM_STALL_CNT_EN is defined.
module vram_scheduler #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] NAME_BASE = 14'h3800,
  parameter logic [ADDR_W-1:0] PAT_BASE  = 14'h0000
) (
  input  logic            clk,
  input  logic            reset,
  vram_scheduler_if.slave bus
);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_VNAME, SLOT_VPAT, SLOT_CPU} slot_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_VNAME, TAG_VPAT, TAG_CPURD} tag_e;

  slot_e             slot;
  logic              in_window;
  logic [4:0]        col;

  tag_e              tag0_q, tag0_d, tag1_q;
  logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
  logic              ramWe_q, ramWe_d;
  logic [7:0]        ramWData_q, ramWData_d;
  logic              cpuAck_q, cpuAck_d;
  logic [7:0]        cpuRData_q, cpuRData_d;
  logic [7:0]        tileName_q, tileName_d;
  logic [7:0]        tilePattern_q, tilePattern_d;
  logic              patValid_q, patValid_d;
  logic              busy_q, busy_d;

  // Slot decode is purely combinational on the current position, so line/frame wraps need no care.
  always_comb begin
    in_window = ~bus.yPos[8] && (bus.yPos[7:0] < 8'd192) &&
                (bus.xPos[8] ? (bus.xPos[8:3] == 6'h3F) : (bus.xPos[7:3] != 5'd31));
    col  = bus.xPos[7:3] + 5'd1;
    slot = SLOT_IDLE;
    if (in_window && bus.xPos[2:0] == 3'd0)      slot = SLOT_VNAME;
    else if (in_window && bus.xPos[2:0] == 3'd4) slot = SLOT_VPAT;
    else if (bus.cpuReq && !busy_q)              slot = SLOT_CPU;
  end

  always_comb begin
    ramAddr_d     = ramAddr_q;
    ramWe_d       = 1'b0;
    ramWData_d    = ramWData_q;
    tag0_d        = TAG_NONE;
    cpuAck_d      = 1'b0;
    cpuRData_d    = cpuRData_q;
    tileName_d    = tileName_q;
    tilePattern_d = tilePattern_q;
    patValid_d    = 1'b0;
    busy_d        = busy_q;

    // Busy stays up through the visible ack cycle so the same held request is not re-issued.
    if (cpuAck_q) busy_d = 1'b0;

    case (slot)
      SLOT_VNAME: begin
        ramAddr_d = NAME_BASE + ADDR_W'({bus.yPos[7:3], col});
        tag0_d    = TAG_VNAME;
      end
      SLOT_VPAT: begin
        ramAddr_d = PAT_BASE + ADDR_W'({tileName_q, bus.yPos[2:0]});
        tag0_d    = TAG_VPAT;
      end
      SLOT_CPU: begin
        ramAddr_d  = bus.cpuAddr;
        ramWe_d    = bus.cpuWe;
        ramWData_d = bus.cpuWData;
        busy_d     = 1'b1;
        if (bus.cpuWe) cpuAck_d = 1'b1;
        else           tag0_d   = TAG_CPURD;
      end
      default: ;
    endcase

    case (tag1_q)
      TAG_VNAME: tileName_d = bus.ramRData;
      TAG_VPAT: begin
        tilePattern_d = bus.ramRData;
        patValid_d    = 1'b1;
      end
      TAG_CPURD: begin
        cpuRData_d = bus.ramRData;
        cpuAck_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag0_q        <= TAG_NONE;
      tag1_q        <= TAG_NONE;
      ramAddr_q     <= '0;
      ramWe_q       <= 1'b0;
      ramWData_q    <= '0;
      cpuAck_q      <= 1'b0;
      cpuRData_q    <= '0;
      tileName_q    <= '0;
      tilePattern_q <= '0;
      patValid_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      tag0_q        <= tag0_d;
      tag1_q        <= tag0_q;
      ramAddr_q     <= ramAddr_d;
      ramWe_q       <= ramWe_d;
      ramWData_q    <= ramWData_d;
      cpuAck_q      <= cpuAck_d;
      cpuRData_q    <= cpuRData_d;
      tileName_q    <= tileName_d;
      tilePattern_q <= tilePattern_d;
      patValid_q    <= patValid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.ramAddr     = ramAddr_q;
  assign bus.ramWe       = ramWe_q;
  assign bus.ramWData    = ramWData_q;
  assign bus.cpuAck      = cpuAck_q;
  assign bus.cpuRData    = cpuRData_q;
  assign bus.tileName    = tileName_q;
  assign bus.tilePattern = tilePattern_q;
  assign bus.patValid    = patValid_q;

`ifdef VRAM_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        vsync_q;

  // A vSync rising edge clears the count even if a stall happens on the same edge.
  always_comb begin
    stall_d = stall_q;
    if (bus.vSync && !vsync_q)
      stall_d = '0;
    else if (bus.cpuReq && !busy_q && slot != SLOT_CPU && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      vsync_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      vsync_q <= bus.vSync;
    end
  end

  assign bus.stallCount = stall_q;
`else
  logic unused_vsync;
  assign unused_vsync   = bus.vSync;
  assign bus.stallCount = 16'h0;
`endif

endmodule

// File: tb/tb_vram_scheduler.sv
// tb/tb_vram_scheduler.sv - directed bench for vram_scheduler
module tb_vram_scheduler;

`ifdef VRAM_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   acks;
  int   pv;

  vram_scheduler_if #(.ADDR_W(14)) bus ();

  vram_scheduler #(.ADDR_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM: low address byte, except a few seeded locations.
  function automatic logic [7:0] ram_model(input logic [13:0] a);
    case (a)
      14'h3823: return 8'h41;
      14'h0209: return 8'hC3;
      14'h0155: return 8'hA7;
      default:  return a[7:0];
    endcase
  endfunction

  always @(posedge clk) bus.ramRData <= ram_model(bus.ramAddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.xPos     = 9'd300;
    bus.yPos     = 9'd0;
    bus.vSync    = 1'b0;
    bus.cpuReq   = 1'b0;
    bus.cpuWe    = 1'b0;
    bus.cpuAddr  = '0;
    bus.cpuWData = '0;
    repeat (2) cyc();
    check("rst_ramAddr",  32'(bus.ramAddr), 32'h0);
    check("rst_ramWe",    32'(bus.ramWe), 32'h0);
    check("rst_cpuAck",   32'(bus.cpuAck), 32'h0);
    check("rst_patValid", 32'(bus.patValid), 32'h0);
    check("rst_stall",    32'(bus.stallCount), 32'h0);

    // Reset in the middle of a CPU read: no ack may ever surface.
    reset = 1'b1;
    cyc();
    bus.cpuReq  = 1'b1;
    bus.cpuWe   = 1'b0;
    bus.cpuAddr = 14'h0123;
    cyc();
    check("t1_issue", 32'(bus.ramAddr), 32'h0123);
    cyc();
    reset      = 1'b0;
    bus.cpuReq = 1'b0;
    #1;
    check("t1_async_clr", 32'(bus.ramAddr), 32'h0);
    cyc();
    reset = 1'b1;
    acks  = 0;
    repeat (5) begin
      cyc();
      if (bus.cpuAck) acks++;
    end
    check("t1_no_ack",   32'(acks), 32'h0);
    check("t1_cpuRData", 32'(bus.cpuRData), 32'h0);

    // CPU write outside the window.
    bus.xPos     = 9'd300;
    bus.cpuWe    = 1'b1;
    bus.cpuAddr  = 14'h1234;
    bus.cpuWData = 8'h5A;
    bus.cpuReq   = 1'b1;
    cyc();
    check("t4_ramWe",    32'(bus.ramWe), 32'h1);
    check("t4_ramAddr",  32'(bus.ramAddr), 32'h1234);
    check("t4_ramWData", 32'(bus.ramWData), 32'h5A);
    check("t4_cpuAck",   32'(bus.cpuAck), 32'h1);
    bus.cpuReq = 1'b0;
    cyc();
    check("t4_we_drop",  32'(bus.ramWe), 32'h0);
    check("t4_ack_drop", 32'(bus.cpuAck), 32'h0);
    cyc();

    // Tile column 31 and line 192 are outside the window: CPU issues immediately.
    bus.yPos     = 9'd9;
    bus.xPos     = 9'd248;
    bus.cpuAddr  = 14'h0777;
    bus.cpuWData = 8'h11;
    bus.cpuReq   = 1'b1;
    cyc();
    check("tile31_addr", 32'(bus.ramAddr), 32'h0777);
    check("tile31_we",   32'(bus.ramWe), 32'h1);
    bus.cpuReq = 1'b0;
    repeat (2) cyc();
    bus.yPos     = 9'd192;
    bus.xPos     = 9'd0;
    bus.cpuAddr  = 14'h0888;
    bus.cpuWData = 8'h22;
    bus.cpuReq   = 1'b1;
    cyc();
    check("y192_addr", 32'(bus.ramAddr), 32'h0888);
    check("y192_we",   32'(bus.ramWe), 32'h1);
    bus.cpuReq = 1'b0;
    bus.cpuWe  = 1'b0;
    repeat (2) cyc();

    // Prefetch of tile 0 on line 0.
    bus.yPos = 9'd0;
    pv = 0;
    for (int p = 0; p < 10; p++) begin
      bus.xPos = 9'(9'h1F8 + p);
      cyc();
      if (p == 0) check("t2_vname", 32'(bus.ramAddr), 32'h3800);
      if (p == 1) check("t2_hold",  32'(bus.ramAddr), 32'h3800);
      if (p == 4) check("t2_vpat",  32'(bus.ramAddr), 32'h0000);
      if (bus.patValid) pv++;
    end
    check("t2_pv_once",  32'(pv), 32'h1);
    check("t2_tileName", 32'(bus.tileName), 32'h0);

    // Line 9, tile at xPos=16 fetches column 3.
    bus.yPos = 9'd9;
    for (int p = 0; p < 8; p++) begin
      bus.xPos = 9'(16 + p);
      cyc();
      if (p == 0) check("t3_vname",    32'(bus.ramAddr), 32'h3823);
      if (p == 2) check("t3_tileName", 32'(bus.tileName), 32'h41);
      if (p == 4) check("t3_vpat",     32'(bus.ramAddr), 32'h0209);
      if (p == 6) check("t3_pattern",  32'(bus.tilePattern), 32'hC3);
      if (p == 6) check("t3_pv",       32'(bus.patValid), 32'h1);
      if (p == 7) check("t3_pv_end",   32'(bus.patValid), 32'h0);
    end

    // CPU read lands just before a name slot and must wait one cycle.
    bus.cpuWe   = 1'b0;
    bus.cpuAddr = 14'h0155;
    bus.cpuReq  = 1'b1;
    for (int p = 0; p < 8; p++) begin
      bus.xPos = 9'(24 + p);
      cyc();
      if (p == 0) check("t5_vname_wins", 32'(bus.ramAddr), 32'h3824);
      if (p == 1) check("t5_cpu_issue",  32'(bus.ramAddr), 32'h0155);
      if (p == 2) check("t5_no_ack_yet", 32'(bus.cpuAck), 32'h0);
      if (p == 3) begin
        check("t5_ack",    32'(bus.cpuAck), 32'h1);
        check("t5_rdata",  32'(bus.cpuRData), 32'hA7);
        bus.cpuReq = 1'b0;
      end
      if (p == 4) check("t5_vpat",     32'(bus.ramAddr), 32'h0121);
      if (p == 6) check("t5_pattern",  32'(bus.tilePattern), 32'h21);
      if (p == 6) check("t5_tileName", 32'(bus.tileName), 32'h24);
    end
    check("t5_stall", 32'(bus.stallCount), STALL_EN ? 32'h1 : 32'h0);

    // Stall counting across held video slots, then vSync clear.
    bus.vSync = 1'b1;
    cyc();
    check("t6_clear0", 32'(bus.stallCount), 32'h0);
    bus.vSync  = 1'b0;
    cyc();
    bus.xPos   = 9'd32;
    bus.cpuReq = 1'b1;
    repeat (3) cyc();
    check("t6_stall3", 32'(bus.stallCount), STALL_EN ? 32'h3 : 32'h0);
    check("t6_no_cpu", 32'(bus.ramAddr), 32'h3825);
    bus.vSync = 1'b1;
    cyc();
    check("t6_clear_wins", 32'(bus.stallCount), 32'h0);
    bus.cpuReq = 1'b0;
    bus.vSync  = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
